// File: rtl/score_bcd_sequencer_pkg.sv
// Shared types and constants for the score BCD sequencer.
//   state_e      : sequencer states (IDLE / CONVERT / EMIT)
//   POS_*        : digit position codes driven on dig_pos
//   dig_s        : registered digit payload presented to the renderer
package score_bcd_sequencer_pkg;

    localparam int unsigned BIN_W      = 8;
    localparam int unsigned SHIFT_W    = 20;
    localparam int unsigned ITERATIONS = 8;
    localparam int unsigned CNT_W      = 3;

    localparam logic [1:0] POS_HUNDREDS = 2'd2;
    localparam logic [1:0] POS_TENS     = 2'd1;
    localparam logic [1:0] POS_ONES     = 2'd0;

    localparam logic [3:0] BLANK_CODE_DEFAULT = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        EMIT    = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] pos;
        logic       src;
        logic       last;
    } dig_s;

endpackage

// File: rtl/score_bcd_sequencer_dabble.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left by 1.
//   data_i : 20-bit working register {hundreds, tens, ones, binary}
//   data_o : register after one adjust+shift step (modulo 20 bits)
module bcd_dabble_step
    import score_bcd_sequencer_pkg::*;
(
    input  logic [SHIFT_W-1:0] data_i,
    output logic [SHIFT_W-1:0] data_o
);

    logic [SHIFT_W-1:0] adj;

    always_comb begin
        adj = data_i;
        for (int i = 0; i < 3; i++) begin
            if (data_i[BIN_W + 4*i +: 4] >= 4'd5) begin
                adj[BIN_W + 4*i +: 4] = data_i[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        data_o = {adj[SHIFT_W-2:0], 1'b0};
    end

endmodule

// File: rtl/score_bcd_sequencer.sv
// Round-robin score converter: grants one player, runs 8 double-dabble steps,
// then streams hundreds/tens/ones digits over a valid/ready handshake.
//   req/gnt         : per-player request, one-cycle one-hot grant
//   bin0/bin1       : player scores, sampled on the grant edge
//   dig_*           : digit stream to the renderer (dig_last marks the ones digit)
module score_bcd_sequencer
    import score_bcd_sequencer_pkg::*;
#(
    parameter bit         BLANK_LEADING = 1'b1,
    parameter logic [3:0] BLANK_CODE    = BLANK_CODE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [BIN_W-1:0] bin0,
    input  logic [BIN_W-1:0] bin1,
    output logic [1:0]       gnt,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [3:0]       dig_data,
    output logic [1:0]       dig_pos,
    output logic             dig_src,
    output logic             dig_last
);

    state_e             state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d, step_c;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               src_q, src_d;
    logic               ptr_q, ptr_d;
    logic [1:0]         pos_q, pos_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               dig_valid_q, dig_valid_d;
    dig_s               dig_q, dig_d;
    logic               winner_c;
    logic               handshake_c;
    logic               last_iter_c;

    // Pointer only matters on a tie; a lone request always wins.
    assign winner_c    = (req == 2'b11) ? ptr_q : req[1];
    assign handshake_c = dig_valid_q & dig_ready;
    assign last_iter_c = (cnt_q == CNT_W'(ITERATIONS - 1));

    bcd_dabble_step u_step (
        .data_i (shift_q),
        .data_o (step_c)
    );

    // Leading-zero blanking: tens blanks only when hundreds is also zero.
    function automatic logic [3:0] pick_digit(input logic [11:0] bcd, input logic [1:0] pos);
        logic [3:0] h, t, o;
        h = bcd[11:8];
        t = bcd[7:4];
        o = bcd[3:0];
        if (pos == POS_HUNDREDS) begin
            return (BLANK_LEADING && h == 4'd0) ? BLANK_CODE : h;
        end else if (pos == POS_TENS) begin
            return (BLANK_LEADING && h == 4'd0 && t == 4'd0) ? BLANK_CODE : t;
        end
        return o;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req != 2'b00) state_d = CONVERT;
            CONVERT: if (last_iter_c) state_d = EMIT;
            EMIT:    if (handshake_c && pos_q == POS_ONES) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; outputs are computed from next state so they register in step.
    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        ptr_d       = ptr_q;
        pos_d       = pos_q;
        gnt_d       = 2'b00;
        dig_valid_d = 1'b0;
        dig_d       = '0;

        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    shift_d = {{(SHIFT_W - BIN_W){1'b0}}, (winner_c ? bin1 : bin0)};
                    cnt_d   = '0;
                    src_d   = winner_c;
                    ptr_d   = ~winner_c;
                    gnt_d   = winner_c ? 2'b10 : 2'b01;
                end
            end
            CONVERT: begin
                shift_d = step_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_iter_c) pos_d = POS_HUNDREDS;
            end
            EMIT: begin
                if (handshake_c && pos_q != POS_ONES) pos_d = pos_q - 2'd1;
            end
            default: ;
        endcase

        if (state_d == EMIT) begin
            dig_valid_d = 1'b1;
            dig_d.data  = pick_digit(shift_d[SHIFT_W-1:BIN_W], pos_d);
            dig_d.pos   = pos_d;
            dig_d.src   = src_d;
            dig_d.last  = (pos_d == POS_ONES);
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            src_q       <= 1'b0;
            ptr_q       <= 1'b0;
            pos_q       <= '0;
            gnt_q       <= '0;
            dig_valid_q <= 1'b0;
            dig_q       <= '0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            ptr_q       <= ptr_d;
            pos_q       <= pos_d;
            gnt_q       <= gnt_d;
            dig_valid_q <= dig_valid_d;
            dig_q       <= dig_d;
        end
    end

    assign gnt       = gnt_q;
    assign dig_valid = dig_valid_q;
    assign dig_data  = dig_q.data;
    assign dig_pos   = dig_q.pos;
    assign dig_src   = dig_q.src;
    assign dig_last  = dig_q.last;

endmodule
